// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM encoding, ACK polarity and SDA drive mnemonics.
// Used by both the I2C master and the I2C slave.
package i2c_pkg;

    localparam int unsigned I2C_BYTE_W    = 8;
    localparam int unsigned I2C_BIT_CNT_W = 3;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Open-drain SDA enable: DRIVE pulls the line low, RELEASE lets it float high.
    localparam logic I2C_OEN_DRIVE   = 1'b1;
    localparam logic I2C_OEN_RELEASE = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_REG,
        ST_ACK_REG,
        ST_WRITE,
        ST_ACK_WR,
        ST_READ,
        ST_ACK_R,
        ST_WAIT
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with edge and START/STOP detection.
// All outputs are registered so the pulses and sampled SDA stay mutually aligned.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det,
    output logic o_sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl_s;
    logic                   w_sda_s;

    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

    // Lines reset to the idle-high level so no edge is seen coming out of reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_scl_sync  <= '1;
            r_sda_sync  <= '1;
            r_scl_d     <= 1'b1;
            r_sda_d     <= 1'b1;
            o_scl_rise  <= 1'b0;
            o_scl_fall  <= 1'b0;
            o_start_det <= 1'b0;
            o_stop_det  <= 1'b0;
            o_sda_s     <= 1'b1;
        end else begin
            r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_d     <= w_scl_s;
            r_sda_d     <= w_sda_s;
            o_scl_rise  <= w_scl_s & ~r_scl_d;
            o_scl_fall  <= ~w_scl_s & r_scl_d;
            o_start_det <= w_scl_s & r_sda_d & ~w_sda_s;
            o_stop_det  <= w_scl_s & ~r_sda_d & w_sda_s;
            o_sda_s     <= w_sda_s;
        end
    end

endmodule

// File: rtl/i2c_slave.sv
// I2C target with 7-bit address and 8-bit auto-incrementing register pointer.
// Serves a simple register-file port; SDA is open-drain, no clock stretching.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       I2C_SCL_I,
    input  logic       I2C_SDA_I,
    output logic       I2C_SDA_OEn,
    output logic       I2C_SDA_O,
    output logic [7:0] Reg_Addr,
    output logic [7:0] Wr_Data,
    output logic       Wr_Strobe,
    output logic       Rd_Strobe,
    input  logic [7:0] Rd_Data,
    output logic       Busy
);

    localparam logic [I2C_BIT_CNT_W-1:0] LAST_BIT = '1;

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda_s;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_scl       (I2C_SCL_I),
        .i_sda       (I2C_SDA_I),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_det (w_start),
        .o_stop_det  (w_stop),
        .o_sda_s     (w_sda_s)
    );

    i2c_state_e               r_state,   w_state;
    logic [I2C_BIT_CNT_W-1:0] r_cnt,     w_cnt;
    logic [I2C_BYTE_W-1:0]    r_shift,   w_shift;
    logic [I2C_BYTE_W-1:0]    r_ptr,     w_ptr;
    logic [I2C_BYTE_W-1:0]    r_wr_data, w_wr_data;
    logic                     r_oen,     w_oen;
    logic                     r_busy,    w_busy;
    logic                     r_wr_stb,  w_wr_stb;
    logic                     r_rd_stb,  w_rd_stb;
    logic                     r_mack,    w_mack;
    logic                     r_rw,      w_rw;
    logic [I2C_BYTE_W-1:0]    w_rx_byte;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_wr_data <= '0;
            r_oen     <= I2C_OEN_RELEASE;
            r_busy    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_rd_stb  <= 1'b0;
            r_mack    <= I2C_NACK;
            r_rw      <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_shift   <= w_shift;
            r_ptr     <= w_ptr;
            r_wr_data <= w_wr_data;
            r_oen     <= w_oen;
            r_busy    <= w_busy;
            r_wr_stb  <= w_wr_stb;
            r_rd_stb  <= w_rd_stb;
            r_mack    <= w_mack;
            r_rw      <= w_rw;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_shift   = r_shift;
        w_ptr     = r_ptr;
        w_wr_data = r_wr_data;
        w_oen     = r_oen;
        w_busy    = r_busy;
        w_wr_stb  = 1'b0;
        w_rd_stb  = 1'b0;
        w_mack    = r_mack;
        w_rw      = r_rw;
        w_rx_byte = {r_shift[I2C_BYTE_W-2:0], w_sda_s};

        // Pointer advances the cycle after a write strobe so Reg_Addr is stable during it.
        if (r_wr_stb) begin
            w_ptr = r_ptr + 8'd1;
        end

        case (r_state)
            ST_ADDR: begin
                if (w_scl_rise) begin
                    w_shift = w_rx_byte;
                    w_cnt   = r_cnt + 3'd1;
                    if (r_cnt == LAST_BIT) begin
                        if (w_rx_byte[7:1] == SLAVE_ADDR) begin
                            w_state = ST_ACK_ADDR;
                            w_rw    = w_rx_byte[0];
                        end else begin
                            w_state = ST_IDLE;
                            w_oen   = I2C_OEN_RELEASE;
                            w_busy  = 1'b0;
                        end
                    end
                end
            end
            ST_ACK_ADDR: begin
                // First fall starts the ACK low phase, the second ends it.
                if (w_scl_fall) begin
                    if (r_oen == I2C_OEN_RELEASE) begin
                        w_oen  = I2C_OEN_DRIVE;
                        w_busy = 1'b1;
                    end else begin
                        w_oen = I2C_OEN_RELEASE;
                        if (r_rw) begin
                            w_state  = ST_READ;
                            w_rd_stb = 1'b1;
                            w_cnt    = '0;
                        end else begin
                            w_state = ST_REG;
                        end
                    end
                end
            end
            ST_REG: begin
                if (w_scl_rise) begin
                    w_shift = w_rx_byte;
                    w_cnt   = r_cnt + 3'd1;
                    if (r_cnt == LAST_BIT) begin
                        w_ptr   = w_rx_byte;
                        w_state = ST_ACK_REG;
                    end
                end
            end
            ST_ACK_REG, ST_ACK_WR: begin
                if (w_scl_fall) begin
                    if (r_oen == I2C_OEN_RELEASE) begin
                        w_oen = I2C_OEN_DRIVE;
                    end else begin
                        w_oen   = I2C_OEN_RELEASE;
                        w_state = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (w_scl_rise) begin
                    w_shift = w_rx_byte;
                    w_cnt   = r_cnt + 3'd1;
                    if (r_cnt == LAST_BIT) begin
                        w_wr_data = w_rx_byte;
                        w_wr_stb  = 1'b1;
                        w_state   = ST_ACK_WR;
                    end
                end
            end
            ST_READ: begin
                // Rd_Data arrives one cycle after the strobe; its MSB goes out at once.
                if (r_rd_stb) begin
                    w_shift = Rd_Data;
                    w_oen   = Rd_Data[7] ? I2C_OEN_RELEASE : I2C_OEN_DRIVE;
                end else if (w_scl_fall) begin
                    if (r_cnt == LAST_BIT) begin
                        w_oen   = I2C_OEN_RELEASE;
                        w_cnt   = '0;
                        w_state = ST_ACK_R;
                    end else begin
                        w_shift = {r_shift[I2C_BYTE_W-2:0], 1'b0};
                        w_oen   = r_shift[6] ? I2C_OEN_RELEASE : I2C_OEN_DRIVE;
                        w_cnt   = r_cnt + 3'd1;
                    end
                end
            end
            ST_ACK_R: begin
                if (w_scl_rise) begin
                    w_mack = w_sda_s;
                    if (w_sda_s == I2C_ACK) begin
                        w_ptr = r_ptr + 8'd1;
                    end
                end else if (w_scl_fall) begin
                    if (r_mack == I2C_NACK) begin
                        w_state = ST_WAIT;
                    end else begin
                        w_state  = ST_READ;
                        w_rd_stb = 1'b1;
                        w_cnt    = '0;
                    end
                end
            end
            ST_IDLE, ST_WAIT: begin
            end
            default: begin
                w_state = ST_IDLE;
                w_oen   = I2C_OEN_RELEASE;
            end
        endcase

        // Bus conditions override everything; STOP has priority over START.
        if (w_stop) begin
            w_state = ST_IDLE;
            w_oen   = I2C_OEN_RELEASE;
            w_busy  = 1'b0;
        end else if (w_start) begin
            w_state = ST_ADDR;
            w_oen   = I2C_OEN_RELEASE;
            w_cnt   = '0;
        end
    end

    assign I2C_SDA_OEn = r_oen;
    assign I2C_SDA_O   = 1'b0;
    assign Reg_Addr    = r_ptr;
    assign Wr_Data     = r_wr_data;
    assign Wr_Strobe   = r_wr_stb;
    assign Rd_Strobe   = r_rd_stb;
    assign Busy        = r_busy;

endmodule
